// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID pipeline register and fetch counter.
// Latency: one edge from imem_addr to IF/ID. stall=1 freezes every register, and redirects are dropped while stalled.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_add_4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_add_4;
        logic        valid;
    } if_id_t;

    logic [31:0] pc_q;
    logic [31:0] pc_add_4;
    logic [31:0] next_pc;
    logic [31:0] fetch_count_q;
    logic        redirect;
    logic        squash;
    if_id_t      if_id_q;

    assign pc_add_4 = pc_q + 32'd4;
    assign redirect = (br_taken | jmp_taken) & ~stall;
    assign squash   = redirect & ~DELAY_SLOT;

    // Jump outranks branch; targets are forced word-aligned.
    always_comb begin
        next_pc = pc_add_4;
        if (stall) begin
            next_pc = pc_q;
        end else if (jmp_taken) begin
            next_pc = {jmp_target[31:2], 2'b00};
        end else if (br_taken) begin
            next_pc = {br_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_q       <= '0;
            fetch_count_q <= '0;
        end else if (!stall) begin
            pc_q <= next_pc;
            if (squash) begin
                if_id_q <= '0;
            end else begin
                if_id_q.instr    <= imem_rdata;
                if_id_q.pc_add_4 <= pc_add_4;
                if_id_q.valid    <= 1'b1;
                fetch_count_q    <= fetch_count_q + 32'd1;
            end
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_add_4 = if_id_q.pc_add_4;
    assign if_id_valid    = if_id_q.valid;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: one instance with a delay slot, one without, driven by the same stimulus.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_taken;
    logic [31:0] jmp_target;

    logic [31:0] addr_ds, instr_ds, pc4_ds, cnt_ds;
    logic        valid_ds;
    logic [31:0] addr_sq, instr_sq, pc4_sq, cnt_sq;
    logic        valid_sq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory returns each word's own address.
    if_fetch_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) dut_ds (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_taken(jmp_taken), .jmp_target(jmp_target),
        .imem_rdata(addr_ds), .imem_addr(addr_ds),
        .if_id_instr(instr_ds), .if_id_pc_add_4(pc4_ds),
        .if_id_valid(valid_ds), .fetch_count(cnt_ds)
    );

    if_fetch_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) dut_sq (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_taken(jmp_taken), .jmp_target(jmp_target),
        .imem_rdata(addr_sq), .imem_addr(addr_sq),
        .if_id_instr(instr_sq), .if_id_pc_add_4(pc4_sq),
        .if_id_valid(valid_sq), .fetch_count(cnt_sq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr,
                             input logic [31:0] e_instr_ds, input logic [31:0] e_pc4_ds,
                             input logic e_valid_ds, input logic [31:0] e_cnt_ds,
                             input logic [31:0] e_instr_sq, input logic [31:0] e_pc4_sq,
                             input logic e_valid_sq, input logic [31:0] e_cnt_sq);
        check({tag, " addr_ds"},  addr_ds, e_addr);
        check({tag, " addr_sq"},  addr_sq, e_addr);
        check({tag, " instr_ds"}, instr_ds, e_instr_ds);
        check({tag, " pc4_ds"},   pc4_ds, e_pc4_ds);
        check({tag, " valid_ds"}, {31'd0, valid_ds}, {31'd0, e_valid_ds});
        check({tag, " count_ds"}, cnt_ds, e_cnt_ds);
        check({tag, " instr_sq"}, instr_sq, e_instr_sq);
        check({tag, " pc4_sq"},   pc4_sq, e_pc4_sq);
        check({tag, " valid_sq"}, {31'd0, valid_sq}, {31'd0, e_valid_sq});
        check({tag, " count_sq"}, cnt_sq, e_cnt_sq);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        br_taken = 1'b0; br_target = '0;
        jmp_taken = 1'b0; jmp_target = '0;
        #2;
        check_all("reset", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        reset = 1'b0;
        step();
        check_all("seq1", 32'h3004, 32'h3000, 32'h3004, 1, 1, 32'h3000, 32'h3004, 1, 1);
        step();
        check_all("seq2", 32'h3008, 32'h3004, 32'h3008, 1, 2, 32'h3004, 32'h3008, 1, 2);

        stall = 1'b1;
        step();
        check_all("stall1", 32'h3008, 32'h3004, 32'h3008, 1, 2, 32'h3004, 32'h3008, 1, 2);
        step();
        check_all("stall2", 32'h3008, 32'h3004, 32'h3008, 1, 2, 32'h3004, 32'h3008, 1, 2);
        stall = 1'b0;
        step();
        check_all("unstall", 32'h300C, 32'h3008, 32'h300C, 1, 3, 32'h3008, 32'h300C, 1, 3);

        // Misaligned target checks the forced alignment too.
        br_taken = 1'b1; br_target = 32'h3042;
        step();
        check_all("branch", 32'h3040, 32'h300C, 32'h3010, 1, 4, 0, 0, 0, 3);
        br_taken = 1'b0;
        step();
        check_all("br_tgt", 32'h3044, 32'h3040, 32'h3044, 1, 5, 32'h3040, 32'h3044, 1, 4);

        jmp_taken = 1'b1; jmp_target = 32'h3101;
        br_taken = 1'b1; br_target = 32'h3200;
        stall = 1'b1;
        step();
        check_all("redir_stalled", 32'h3044, 32'h3040, 32'h3044, 1, 5, 32'h3040, 32'h3044, 1, 4);
        stall = 1'b0;
        step();
        check_all("jmp_prio", 32'h3100, 32'h3044, 32'h3048, 1, 6, 0, 0, 0, 4);
        br_taken = 1'b0;
        jmp_target = 32'hFFFF_FFFC;
        step();
        check_all("jmp_top", 32'hFFFF_FFFC, 32'h3100, 32'h3104, 1, 7, 0, 0, 0, 4);
        jmp_taken = 1'b0;
        step();
        check_all("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0, 1, 8, 32'hFFFF_FFFC, 32'h0, 1, 5);

        // Asynchronous reset between edges, with a redirect pending.
        br_taken = 1'b1; br_target = 32'h4000;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        check_all("post_rst", 32'h3004, 32'h3000, 32'h3004, 1, 1, 32'h3000, 32'h3004, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
